// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - mode/phase enums and direction helper for the intersection sequencer
package traffic_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL     = 2'd0,
    MODE_PEDESTRIAN = 2'd1,
    MODE_EMERGENCY  = 2'd2,
    MODE_NIGHT      = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    PH_ALL_RED = 3'd0,
    PH_GREEN   = 3'd1,
    PH_YELLOW  = 3'd2,
    PH_WALK    = 3'd3,
    PH_FLASH   = 3'd4
  } phase_e;

  function automatic int unsigned next_dir(input int unsigned dir, input int unsigned num_dirs);
    return (dir + 1 >= num_dirs) ? 0 : dir + 1;
  endfunction

endpackage

// File: rtl/traffic_mode_ctrl_if.sv
// rtl/traffic_mode_ctrl_if.sv - condition inputs and lamp-side outputs; TRAFFIC_EMG_LOG_EN adds emgCount
interface traffic_mode_ctrl_if #(parameter int DIR_W = 1);

  logic             timeSignal;
  logic             pedSignal;
  logic             emgSignal;
  logic [DIR_W-1:0] emgDir;
  logic [1:0]       trafficModeOutput;
  logic [DIR_W-1:0] activeDir;
  logic [2:0]       phase;
  logic             flashOn;
  logic             pedPending;
`ifdef TRAFFIC_EMG_LOG_EN
  logic [7:0]       emgCount;
`endif

  modport master (
    output timeSignal, pedSignal, emgSignal, emgDir,
`ifdef TRAFFIC_EMG_LOG_EN
    input  emgCount,
`endif
    input  trafficModeOutput, activeDir, phase, flashOn, pedPending
  );

  modport slave (
    input  timeSignal, pedSignal, emgSignal, emgDir,
`ifdef TRAFFIC_EMG_LOG_EN
    output emgCount,
`endif
    output trafficModeOutput, activeDir, phase, flashOn, pedPending
  );

endinterface

// File: rtl/traffic_mode_ctrl_phase_timer.sv
// rtl/traffic_mode_ctrl_phase_timer.sv - loadable down-counter that parks at zero
module phase_timer #(
  parameter int               CNT_W     = 8,
  parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= RESET_VAL;
    else if (load)
      cnt_q <= load_val;
    else if (dec && cnt_q != '0)
      cnt_q <= cnt_q - CNT_W'(1);
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/traffic_mode_ctrl.sv
// rtl/traffic_mode_ctrl.sv - N-direction intersection mode/phase sequencer; TRAFFIC_EMG_LOG_EN adds emgCount
module traffic_mode_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_DIRS       = 2,
  parameter int GREEN_CYCLES   = 8,
  parameter int YELLOW_CYCLES  = 3,
  parameter int ALL_RED_CYCLES = 2,
  parameter int PED_CYCLES     = 6,
  parameter int FLASH_CYCLES   = 4,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic reset,
  traffic_mode_ctrl_if.slave bus
);

  localparam int DIR_W = (NUM_DIRS > 2) ? $clog2(NUM_DIRS) : 1;
  localparam int unsigned ND = NUM_DIRS;
  localparam logic [CNT_W-1:0] LD_GREEN   = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW  = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_ALL_RED = CNT_W'(ALL_RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_WALK    = CNT_W'(PED_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_FLASH   = CNT_W'(FLASH_CYCLES - 1);

  phase_e           phase_q, phase_n;
  mode_e            mode_q, mode_n;
  logic [DIR_W-1:0] dir_q, dir_n, emg_dir;
  logic             flash_q, flash_n;
  logic             ped_q, ped_n, ped_clr;
  logic             served_q, served_n;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_val;

  assign emg_dir = DIR_W'(32'(bus.emgDir) % ND);

  phase_timer #(.CNT_W(CNT_W), .RESET_VAL(LD_ALL_RED)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .dec      (1'b1),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q  <= PH_ALL_RED;
      mode_q   <= MODE_NORMAL;
      dir_q    <= '0;
      flash_q  <= 1'b0;
      ped_q    <= 1'b0;
      served_q <= 1'b0;
    end else begin
      phase_q  <= phase_n;
      mode_q   <= mode_n;
      dir_q    <= dir_n;
      flash_q  <= flash_n;
      ped_q    <= ped_n;
      served_q <= served_n;
    end
  end

  // A request on the clearing edge survives: set wins over clear.
  assign ped_n = (ped_q & ~ped_clr) | bus.pedSignal;

  always_comb begin
    phase_n  = phase_q;
    mode_n   = mode_q;
    dir_n    = dir_q;
    flash_n  = flash_q;
    served_n = served_q;
    ped_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (phase_q)
      PH_ALL_RED: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (bus.emgSignal) begin
            phase_n  = PH_GREEN;
            mode_n   = MODE_EMERGENCY;
            dir_n    = emg_dir;
            served_n = 1'b1;
            tmr_val  = LD_GREEN;
          end else if (ped_q) begin
            phase_n = PH_WALK;
            mode_n  = MODE_PEDESTRIAN;
            ped_clr = 1'b1;
            tmr_val = LD_WALK;
          end else if (bus.timeSignal) begin
            phase_n = PH_FLASH;
            mode_n  = MODE_NIGHT;
            flash_n = 1'b1;
            tmr_val = LD_FLASH;
          end else begin
            // The very first green after reset goes to direction 0 itself.
            phase_n  = PH_GREEN;
            mode_n   = MODE_NORMAL;
            dir_n    = served_q ? DIR_W'(next_dir(32'(dir_q), ND)) : dir_q;
            served_n = 1'b1;
            tmr_val  = LD_GREEN;
          end
        end
      end
      PH_GREEN: begin
        // Emergency on the owning direction parks the timer at zero.
        if ((bus.emgSignal && dir_q != emg_dir) || (tmr_zero && !bus.emgSignal)) begin
          phase_n  = PH_YELLOW;
          tmr_load = 1'b1;
          tmr_val  = LD_YELLOW;
        end
      end
      PH_YELLOW: begin
        if (tmr_zero) begin
          phase_n  = PH_ALL_RED;
          tmr_load = 1'b1;
          tmr_val  = LD_ALL_RED;
        end
      end
      PH_WALK: begin
        if (tmr_zero || bus.emgSignal) begin
          phase_n  = PH_ALL_RED;
          tmr_load = 1'b1;
          tmr_val  = LD_ALL_RED;
        end
      end
      PH_FLASH: begin
        if (!bus.timeSignal || bus.emgSignal || ped_q) begin
          phase_n  = PH_ALL_RED;
          flash_n  = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = LD_ALL_RED;
        end else if (tmr_zero) begin
          flash_n  = ~flash_q;
          tmr_load = 1'b1;
          tmr_val  = LD_FLASH;
        end
      end
      default: begin
        phase_n  = PH_ALL_RED;
        flash_n  = 1'b0;
        tmr_load = 1'b1;
        tmr_val  = LD_ALL_RED;
      end
    endcase
  end

`ifdef TRAFFIC_EMG_LOG_EN
  logic [7:0] emg_cnt_q;
  logic       emg_entry;

  // Re-entry after an emgDir change keeps mode at EMERGENCY, so it is not counted.
  assign emg_entry = (phase_q == PH_ALL_RED) && tmr_zero && bus.emgSignal &&
                     (mode_q != MODE_EMERGENCY);

  always_ff @(posedge clk) begin
    if (reset)
      emg_cnt_q <= 8'd0;
    else if (emg_entry && emg_cnt_q != 8'hFF)
      emg_cnt_q <= emg_cnt_q + 8'd1;
  end

  assign bus.emgCount = emg_cnt_q;
`endif

  assign bus.trafficModeOutput = mode_q;
  assign bus.activeDir         = dir_q;
  assign bus.phase             = phase_q;
  assign bus.flashOn           = flash_q;
  assign bus.pedPending        = ped_q;

endmodule
